// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: pop handshake between the transmit FIFO and the UART serializer
interface uart_tx_serializer_if;
  logic       fifo_rd_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
  modport slave (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and sends 8N1 / 8E1 frames on tx
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_tx,
  uart_tx_serializer_if.master   fif,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          run, tick;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
    end
  // the baud counter only runs while a bit is on the line, so it is zero on entry to START
  assign run  = state_q inside {START, DATA, PARITY, STOP};
  assign tick = run && cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = run ? (tick ? '0 : cnt_q + 1'b1) : '0;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    case (state_q)
      IDLE:    state_d = (start_tx && !fif.fifo_empty) ? REQ : IDLE;
      REQ:     state_d = LOAD;
      LOAD: begin
        sh_d    = fif.fifo_data;
        par_d   = 1'b0;
        idx_d   = '0;
        state_d = START;
      end
      START:   state_d = tick ? DATA : START;
      DATA:
        if (tick) begin
          par_d   = par_q ^ sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? (PARITY_EN ? PARITY : STOP) : DATA;
        end
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  assign tx = (state_q == START) ? 1'b0 :
              (state_q == DATA) ? sh_q[0] :
              (state_q == PARITY) ? par_q : 1'b1;
  assign busy           = state_q != IDLE;
  assign frame_done     = state_q == STOP && tick;
  assign fif.fifo_rd_en = state_q == REQ;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: two serializers (no parity / even parity) fed by FIFO models, scoreboard checks each frame
module tb_uart_tx_serializer;
  localparam int CPB = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_tx = 1'b0;
  logic [1:0] tx, busy, done;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] fq [2][$];
  logic [7:0] expq [2][$];
  int         poptime [2][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      fq[i].push_back(b);
      expq[i].push_back(b);
    end
  endtask
  task automatic wait_pops(input int n);
    int k = 0;
    while ((poptime[0].size() < n || poptime[1].size() < n) && k < 2000) begin
      tick(1);
      k++;
    end
    if (k >= 2000) begin
      compared++;
      mismatched++;
      $display("FAIL pop_timeout: got %0d/%0d pops required %0d", poptime[0].size(), poptime[1].size(), n);
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy != 2'b00 && k < 500) begin
      tick(1);
      k++;
    end
    if (k >= 500) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: got busy=%b required 00", busy);
    end
    tick(3);
  endtask
  function automatic logic [63:0] exp_tx(input logic [7:0] b, input int par);
    logic [10:0] bits;
    logic [63:0] r;
    int n;
    n    = CPB * (10 + par);
    bits = {1'b1, (par != 0) ? ^b : 1'b1, b, 1'b0};
    r    = '0;
    r[0] = 1'b1;
    r[1] = 1'b1;
    for (int f = 0; f < n; f++) r[2+f] = bits[f/CPB];
    r[n+2] = 1'b1;
    return r;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N = CPB * (10 + g);
    uart_tx_serializer_if fif ();
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'(g))) dut (
      .clk(clk), .rst(rst), .start_tx(start_tx), .fif(fif),
      .tx(tx[g]), .busy(busy[g]), .frame_done(done[g])
    );
    always @(negedge clk) begin
      if (fif.fifo_rd_en === 1'b1 && fq[g].size() != 0) fif.fifo_data <= fq[g].pop_front();
      fif.fifo_empty <= (fq[g].size() == 0);
    end
    initial begin : mon
      logic [7:0] b;
      logic [63:0] gtx, gbusy, gdone, grd;
      bit live;
      forever begin
        @(negedge clk);
        if (rst && fif.fifo_rd_en === 1'b1) begin
          poptime[g].push_back(cyc);
          if (expq[g].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_pop[%0d]: got rd_en=1 at cycle %0d required no pop", g, cyc);
          end else begin
            b = expq[g].pop_front();
            live = 1'b1;
            gtx = '0; gbusy = '0; gdone = '0; grd = '0;
            for (int i = 0; i < N + 3; i++) begin
              if (i > 0) @(negedge clk);
              if (!rst) begin
                live = 1'b0;
                break;
              end
              gtx[i]   = tx[g];
              gbusy[i] = busy[g];
              gdone[i] = done[g];
              grd[i]   = fif.fifo_rd_en;
            end
            if (live) begin
              chk($sformatf("frame_tx[%0d] byte %h", g, b), gtx, exp_tx(b, g));
              chk($sformatf("frame_busy[%0d] byte %h", g, b), gbusy, (64'd1 << (N + 2)) - 64'd1);
              chk($sformatf("frame_done[%0d] byte %h", g, b), gdone, 64'd1 << (N + 1));
              chk($sformatf("frame_rd_en[%0d] byte %h", g, b), grd, 64'd1);
            end
          end
        end
      end
    end
  end
  initial begin
    int c;
    int gap [2] = '{43, 47};
    tick(5);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_tx[%0d]", i), 64'(tx[i]), 64'd1);
      chk($sformatf("reset_busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("reset_done[%0d]", i), 64'(done[i]), 64'd0);
      chk($sformatf("reset_rd_en[%0d]", i), 64'(u[0].fif.fifo_rd_en | u[1].fif.fifo_rd_en), 64'd0);
    end
    tick(1);
    rst = 1'b1;
    start_tx = 1'b1;
    tick(20);
    for (int i = 0; i < 2; i++) chk($sformatf("empty_no_pop[%0d]", i), 64'(poptime[i].size()), 64'd0);
    push(8'hA5);
    wait_pops(1);
    wait_idle();
    for (int i = 0; i < 2; i++) chk($sformatf("single_pop_count[%0d]", i), 64'(poptime[i].size()), 64'd1);
    push(8'h07);
    push(8'h5A);
    push(8'hFF);
    wait_pops(4);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("b2b_gap1[%0d]", i), 64'(poptime[i][2] - poptime[i][1]), 64'(gap[i]));
      chk($sformatf("b2b_gap2[%0d]", i), 64'(poptime[i][3] - poptime[i][2]), 64'(gap[i]));
    end
    push(8'h3C);
    push(8'h81);
    wait_pops(5);
    c = poptime[0][4];
    while (cyc < c + 19) tick(1);
    start_tx = 1'b0;
    wait_idle();
    tick(60);
    for (int i = 0; i < 2; i++) chk($sformatf("gated_pop_count[%0d]", i), 64'(poptime[i].size()), 64'd5);
    c = cyc;
    start_tx = 1'b1;
    wait_pops(6);
    for (int i = 0; i < 2; i++) chk($sformatf("regate_pop_time[%0d]", i), 64'(poptime[i][5]), 64'(c + 1));
    wait_idle();
    push(8'h96);
    push(8'h4B);
    wait_pops(7);
    c = poptime[0][6];
    while (cyc < c + 27) tick(1);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset_tx[%0d]", i), 64'(tx[i]), 64'd1);
      chk($sformatf("midreset_busy[%0d]", i), 64'(busy[i]), 64'd0);
    end
    tick(3);
    rst = 1'b1;
    wait_pops(8);
    wait_idle();
    tick(5);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("final_pop_count[%0d]", i), 64'(poptime[i].size()), 64'd8);
      chk($sformatf("final_expq_left[%0d]", i), 64'(expq[i].size()), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Downstream consumer of the 8-bit transmit FIFO. It pops one byte at a time through a read-enable/empty handshake and serializes each byte onto a UART line: 1 start bit, 8 data bits LSB first, an optional even-parity bit, and 1 stop bit. It is gated by the same `start_tx` level that arms transmission. It sits between the FIFO and the board's TX pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range 2..65535.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start_tx` in 1: level enable; a new frame may begin only while it is high.
- `fifo_empty` in 1: the FIFO has no data.
- `fifo_rd_en` out 1: one-cycle pop request to the FIFO.
- `fifo_data` in 8: FIFO read data; valid on the cycle after `fifo_rd_en`.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- **States:** IDLE, REQ, LOAD, START, DATA, PARITY, STOP. All outputs are registered or decoded from the state and counter registers. There are no combinational paths from inputs to outputs.
- **IDLE:**
  - `tx`=1.
  - If `start_tx`=1 and `fifo_empty`=0, go to REQ. Otherwise stay.
- **REQ:**
  - `fifo_rd_en`=1 for exactly this one cycle.
  - Next state is LOAD, unconditionally.
- **LOAD:**
  - Latch `fifo_data` into the 8-bit shift register.
  - Clear the parity accumulator and the baud counter.
  - Go to START.
- **START:**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx` = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles: XOR that bit into parity, shift right, and increment the 3-bit bit index.
  - After index 7 completes, go to PARITY if `PARITY_EN`=1, else go to STOP.
- **PARITY:**
  - `tx` = XOR of the 8 data bits (even parity), held for `CLKS_PER_BIT` cycles.
  - Then go to STOP.
- **STOP:**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - `frame_done`=1 on the final cycle.
  - Then go to IDLE.
- **Baud counter:** width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. It never runs in IDLE, REQ or LOAD.
- **`start_tx` low mid-frame:** the current frame completes unchanged. No further REQ occurs until `start_tx` is high again in IDLE.
- **`fifo_empty` and `fifo_data`:** both are ignored outside IDLE and LOAD respectively. A FIFO going empty mid-frame has no effect.
- **Pops:** never assert `fifo_rd_en` when `fifo_empty`=1 in IDLE. Exactly one pop occurs per frame.
- **Reset, asserted at any time including mid-frame:**
  - State goes to IDLE immediately (asynchronously).
  - `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0.
  - Shift register, counters and parity are cleared.
  - The partially sent byte is discarded, not re-popped.
- **Reset values of outputs:** `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0.

## Timing
- Let N = `CLKS_PER_BIT`×(10+`PARITY_EN`).
- **Pop to start bit:** with the IDLE condition true at cycle t, `fifo_rd_en` is high at t+1. `tx` falls at t+3. The frame occupies cycles t+3..t+2+N.
- **`frame_done`:** high at cycle t+2+N.
- **Return to IDLE:** the block is in IDLE at t+3+N.
- **Back-to-back frames:** with `start_tx`=1 and the FIFO non-empty, the `fifo_rd_en` pulses are spaced exactly N+3 cycles apart. There are 3 idle-high cycles between the stop bit and the next start bit: IDLE, REQ, LOAD.
- **Bit timing:** each bit is exactly `CLKS_PER_BIT` cycles with no drift. Data bit k (k=0..7) occupies frame cycles `CLKS_PER_BIT`×(1+k) .. `CLKS_PER_BIT`×(2+k)-1.
- **`busy`:** high from REQ through the last STOP cycle inclusive.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles -> `tx`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0. Release with `fifo_empty`=1 -> no `fifo_rd_en` ever.
- **Single byte:** `CLKS_PER_BIT`=4, `PARITY_EN`=0, FIFO returns 0xA5 -> `tx` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `frame_done` pulses once at cycle t+42. Exactly one `fifo_rd_en`.
- **Parity:** `PARITY_EN`=1, bytes 0xA5 then 0x07 -> parity bit 0 then 1. Frame length is 44 cycles each.
- **Back-to-back stream:** 3 bytes queued, `start_tx` held high, `CLKS_PER_BIT`=4 -> `fifo_rd_en` pulses at t+1, t+44, t+87. Each gap has 3 high cycles between stop and start.
- **Gating:** drop `start_tx` during data bit 3 of byte 0x3C -> the frame completes correctly and no further pop occurs. Raise `start_tx` again -> the next pop follows 1 cycle later.
- **Reset mid-frame:** assert `rst` during data bit 5 -> `tx`=1 at once. After release, the next frame starts with a fresh pop and transmits the next FIFO byte intact.
